hex_coverage_accumulator: RTL
=============================

// Module: hex_coverage_accumulator
// PURPOSE
//  Sits directly downstream of the screen-to-hex mapper; consumes its (hex_q, hex_r, valid) stream.
//  Counts hits per hex cell in an on-chip RAM using a read-modify-write pipeline at 1 sample/cycle.
//  Supports a full-RAM clear sweep and a streaming dump of all cell counts over a ready/valid port.
//  No backpressure to the upstream stage; samples that cannot be taken are dropped and counted.
// PARAMETERS
//  GRID_W    64  cells per row (column range 0..GRID_W-1)
//  GRID_H    64  rows (row range 0..GRID_H-1)
//  Q_OFFSET  32  added to signed hex_q to give the column
//  R_OFFSET  32  added to signed hex_r to give the row
//  CNT_W     8   per-cell counter width; counters saturate
//  ADDR_W    $clog2(GRID_W*GRID_H)  derived; do not override
// PORTS
//  clk         in   1       single clock, rising edge
//  reset       in   1       synchronous, active-high
//  valid       in   1       hex_q/hex_r qualify this cycle (from mapper valid)
//  hex_q       in   32      axial q, signed two's complement
//  hex_r       in   32      axial r, signed two's complement
//  clear_start in   1       pulse: start clear sweep (honoured only in ACCUM)
//  dump_start  in   1       pulse: start dump (honoured only in ACCUM)
//  busy        out  1       high in any state other than ACCUM
//  dump_valid  out  1       dump beat valid
//  dump_ready  in   1       consumer accepts beat
//  dump_addr   out  ADDR_W  linear cell address of beat
//  dump_count  out  CNT_W   count of that cell
//  dump_last   out  1       high on the final beat (addr = GRID_W*GRID_H-1)
//  drop_oob    out  16      saturating count of out-of-range samples
//  drop_busy   out  16      saturating count of samples dropped while busy
// BEHAVIOUR
//  Reset: every output is 0 except busy, which is 1. The FSM enters CLEAR at addr 0.
//   RAM contents are undefined until that sweep completes. Reset mid-CLEAR or mid-DUMP restarts CLEAR.
//  Address mapping: col = hex_q + Q_OFFSET, row = hex_r + R_OFFSET (32-bit signed arithmetic).
//   In range iff 0<=col<GRID_W and 0<=row<GRID_H; addr = row*GRID_W + col.
//   Out-of-range samples in ACCUM increment drop_oob; the RAM is untouched.
//  Pipeline (ACCUM):
//   S0 registers the range check and address.
//   S1 issues the synchronous RAM read.
//   S2 writes min(rd+1, 2^CNT_W-1).
//   A sample is visible in the RAM 3 cycles after its valid cycle.
//  Hazards: same address on consecutive cycles, or 2 cycles apart, must count exactly.
//   S1 read data is forwarded from the S2 write and from the previous write (2-entry bypass).
//   RAM read-during-write returns old data.
//  FSM states:
//   ACCUM: normal. clear_start -> CLEAR; dump_start -> DRAIN.
//    If both arrive in the same cycle, clear wins and dump is ignored.
//   CLEAR: write 0 to one address per cycle, 0..N-1 (N = GRID_W*GRID_H), then -> ACCUM.
//    Takes N cycles; busy is high throughout.
//   DRAIN: wait until S0..S2 are empty (at most 3 cycles), then -> DUMP at addr 0.
//   DUMP: read addr, present the beat, hold all dump_* stable while dump_valid && !dump_ready.
//    On a handshake, advance addr. The handshake on dump_last -> ACCUM.
//    Counts are not cleared by a dump.
//  While busy: the valid-cycle sample is dropped and drop_busy increments; drop_oob is not also incremented.
//   The sample accepted in the same cycle as clear_start/dump_start completes before the sweep/dump.
//  Start pulses outside ACCUM are ignored.
//  drop_* counters saturate at 0xFFFF and clear only on reset.
// STRUCTURE
//  hex_raster_pkg:
//   - state enum {ACCUM, CLEAR, DRAIN, DUMP}
//   - function axial_to_addr(q, r) returning {in_range, addr}
//   - function sat_inc
//  Sub-module hex_count_ram: simple dual-port, 1 write + 1 sync read port, depth N, width CNT_W.
//   Shared by RMW, CLEAR and DUMP via a mux in the parent.
// TESTING
//  1. Reset, hold 4096 cycles -> busy falls exactly after N=4096 clear cycles; dump shows all counts 0.
//  2. q=0, r=0 valid for 5 consecutive cycles -> dump beat addr 2080 has count 5; all others 0.
//  3. Alternate (q=1,r=0),(q=2,r=0) for 8 cycles, then (q=1,r=0) in cycles with 1 gap
//     -> addr 2081/2082 counts exact (bypass check).
//  4. q=-33, r=0 and q=0, r=32 valid -> drop_oob=2, RAM unchanged.
//     300 hits on one cell -> count saturates at 255.
//  5. dump_start with dump_ready toggling 1/0 -> 4096 beats in order, stable while stalled,
//     dump_last on 4095; valid samples during dump raise drop_busy.
//  6. clear_start and dump_start in the same cycle -> CLEAR only.
//     Reset asserted mid-DUMP -> dump_valid=0 next cycle, busy=1, fresh clear sweep.

Source files
------------

// File: rtl/hex_raster_pkg.sv
// Shared types and helpers for the hex-grid coverage accumulator.
// Axial-to-linear address mapping and saturating increment.
package hex_raster_pkg;

  typedef enum logic [1:0] {
    StAccum,
    StClear,
    StDrain,
    StDump
  } state_e;

  typedef struct packed {
    logic        in_range;
    logic [31:0] addr;
  } hex_loc_t;

  function automatic hex_loc_t axial_to_addr(input logic signed [31:0] q,
                                             input logic signed [31:0] r,
                                             input int grid_w,
                                             input int grid_h,
                                             input int q_off,
                                             input int r_off);
    logic signed [31:0] col;
    logic signed [31:0] row;
    hex_loc_t           loc;
    col          = q + q_off;
    row          = r + r_off;
    loc.in_range = (col >= 0) && (col < grid_w) && (row >= 0) && (row < grid_h);
    loc.addr     = 32'(row * grid_w + col);
    return loc;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
    return (v >= max_v) ? max_v : v + 32'd1;
  endfunction

endpackage

// File: rtl/hex_count_ram.sv
// Simple dual-port count RAM: one write port, one synchronous read port.
// A read of the address being written in the same cycle returns the old contents.
module hex_count_ram #(
  parameter int DEPTH = 4096,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/hex_coverage_accumulator.sv
// Per-hex-cell hit counter: read-modify-write pipeline over a count RAM,
// with a full clear sweep and a ready/valid dump of every cell.
module hex_coverage_accumulator
  import hex_raster_pkg::*;
#(
  parameter int GRID_W   = 64,
  parameter int GRID_H   = 64,
  parameter int Q_OFFSET = 32,
  parameter int R_OFFSET = 32,
  parameter int CNT_W    = 8,
  localparam int ADDR_W  = $clog2(GRID_W * GRID_H)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid,
  input  logic [31:0]       hex_q,
  input  logic [31:0]       hex_r,
  input  logic              clear_start,
  input  logic              dump_start,
  output logic              busy,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [CNT_W-1:0]  dump_count,
  output logic              dump_last,
  output logic [15:0]       drop_oob,
  output logic [15:0]       drop_busy
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(GRID_W * GRID_H - 1);
  localparam logic [31:0]       CntMax   = 32'((1 << CNT_W) - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   clear_addr_q, clear_addr_d;
  logic [ADDR_W-1:0]   dump_addr_q, dump_addr_d;
  logic                dump_valid_q, dump_valid_d;
  logic                s0_valid_q, s1_valid_q;
  logic [ADDR_W-1:0]   s0_addr_q, s1_addr_q;
  logic                wr1_valid_q, wr2_valid_q;
  logic [ADDR_W-1:0]   wr1_addr_q, wr2_addr_q;
  logic [CNT_W-1:0]    wr1_data_q, wr2_data_q;
  logic [15:0]         drop_oob_q, drop_busy_q;

  hex_loc_t            loc;
  logic                accum;
  logic                unused_addr_hi;
  logic [CNT_W-1:0]    rd_fwd;
  logic                rmw_we;
  logic [CNT_W-1:0]    rmw_data;
  logic                ram_we;
  logic [ADDR_W-1:0]   ram_waddr, ram_raddr;
  logic [CNT_W-1:0]    ram_wdata, ram_rdata;

  assign loc            = axial_to_addr(hex_q, hex_r, GRID_W, GRID_H, Q_OFFSET, R_OFFSET);
  assign unused_addr_hi = ^loc.addr[31:ADDR_W];
  assign accum          = (state_q == StAccum);

  // Newest write wins; it covers the read that coincided with it in the RAM.
  always_comb begin
    rd_fwd = ram_rdata;
    if (wr2_valid_q && (wr2_addr_q == s1_addr_q)) rd_fwd = wr2_data_q;
    if (wr1_valid_q && (wr1_addr_q == s1_addr_q)) rd_fwd = wr1_data_q;
  end

  // Writes still in flight when a clear starts are discarded; the sweep zeroes them anyway.
  assign rmw_we   = s1_valid_q && (state_q != StClear);
  assign rmw_data = CNT_W'(sat_inc(32'(rd_fwd), CntMax));

  always_comb begin
    ram_we    = rmw_we;
    ram_waddr = s1_addr_q;
    ram_wdata = rmw_data;
    if (state_q == StClear) begin
      ram_we    = 1'b1;
      ram_waddr = clear_addr_q;
      ram_wdata = '0;
    end
    ram_raddr = (state_q == StDump) ? dump_addr_q : s0_addr_q;
  end

  hex_count_ram #(
    .DEPTH (GRID_W * GRID_H),
    .WIDTH (CNT_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d      = state_q;
    clear_addr_d = clear_addr_q;
    dump_addr_d  = dump_addr_q;
    dump_valid_d = dump_valid_q;
    unique case (state_q)
      StAccum: begin
        if (clear_start) begin
          state_d      = StClear;
          clear_addr_d = '0;
        end else if (dump_start) begin
          state_d = StDrain;
        end
      end
      StClear: begin
        clear_addr_d = clear_addr_q + ADDR_W'(1);
        if (clear_addr_q == LastAddr) state_d = StAccum;
      end
      StDrain: begin
        if (!s0_valid_q && !s1_valid_q) begin
          state_d      = StDump;
          dump_addr_d  = '0;
          dump_valid_d = 1'b0;
        end
      end
      StDump: begin
        // Each beat: one cycle to read, then hold until accepted.
        if (!dump_valid_q) begin
          dump_valid_d = 1'b1;
        end else if (dump_ready) begin
          dump_valid_d = 1'b0;
          if (dump_addr_q == LastAddr) state_d = StAccum;
          else dump_addr_d = dump_addr_q + ADDR_W'(1);
        end
      end
      default: state_d = StClear;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StClear;
      clear_addr_q <= '0;
      dump_addr_q  <= '0;
      dump_valid_q <= 1'b0;
      s0_valid_q   <= 1'b0;
      s0_addr_q    <= '0;
      s1_valid_q   <= 1'b0;
      s1_addr_q    <= '0;
      wr1_valid_q  <= 1'b0;
      wr1_addr_q   <= '0;
      wr1_data_q   <= '0;
      wr2_valid_q  <= 1'b0;
      wr2_addr_q   <= '0;
      wr2_data_q   <= '0;
      drop_oob_q   <= '0;
      drop_busy_q  <= '0;
    end else begin
      state_q      <= state_d;
      clear_addr_q <= clear_addr_d;
      dump_addr_q  <= dump_addr_d;
      dump_valid_q <= dump_valid_d;
      s0_valid_q   <= valid && accum && loc.in_range;
      s0_addr_q    <= ADDR_W'(loc.addr);
      s1_valid_q   <= s0_valid_q && (state_q != StClear);
      s1_addr_q    <= s0_addr_q;
      wr1_valid_q  <= rmw_we;
      wr1_addr_q   <= s1_addr_q;
      wr1_data_q   <= rmw_data;
      wr2_valid_q  <= wr1_valid_q;
      wr2_addr_q   <= wr1_addr_q;
      wr2_data_q   <= wr1_data_q;
      if (valid && !accum) drop_busy_q <= 16'(sat_inc(32'(drop_busy_q), 32'hFFFF));
      if (valid && accum && !loc.in_range) begin
        drop_oob_q <= 16'(sat_inc(32'(drop_oob_q), 32'hFFFF));
      end
    end
  end

  assign busy       = !accum;
  assign dump_valid = dump_valid_q;
  assign dump_addr  = dump_addr_q;
  assign dump_count = dump_valid_q ? ram_rdata : '0;
  assign dump_last  = dump_valid_q && (dump_addr_q == LastAddr);
  assign drop_oob   = drop_oob_q;
  assign drop_busy  = drop_busy_q;

endmodule
